// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path definitions used by fetch_queue, pipeline0 and the hazard unit.
package fetch_queue_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [XLEN-1:0] EXC_VECTOR_DEF = 32'h0000_FFFC;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO with a registered head and a single-cycle flush.
module sync_fifo_fwft #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_pop;

    assign do_pop = pop_i && (count_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_i, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            // Head register tracks what mem_q[rd_ptr] will hold next cycle,
            // bypassing the array when the pushed word becomes the new head.
            if (do_pop) begin
                if (count_q > 1) head_d = mem_q[rd_ptr_d];
                else if (push_i) head_d = push_data_i;
            end else if ((count_q == '0) && push_i) begin
                head_d = push_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i && !reset_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign valid_o = (count_q != '0);
    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues 1-cycle-latency imem
// reads under a credit check, and buffers returns in a flushable FWFT queue.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH      = 4,
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_rd_en,
    output logic [XLEN-1:0]        imem_addr,
    input  logic [XLEN-1:0]        imem_rdata,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    input  logic                   exc_valid,
    output logic                   out_valid,
    output logic [XLEN-1:0]        out_instr,
    output logic [XLEN-1:0]        out_pc,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    logic            pop;
    logic            push;
    logic [CW:0]     credit;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    assign redirect        = exc_valid || redirect_valid;
    assign redirect_target = exc_valid ? EXC_VECTOR : (redirect_pc & 32'hFFFF_FFFC);
    assign pop             = out_valid && out_ready;
    assign push            = inflight_q && !redirect;

    // Outstanding entries after this cycle's pop; at most one request is ever in flight.
    assign credit     = {1'b0, count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    assign imem_rd_en = !reset && (credit < DEPTH_C);
    assign imem_addr  = fetch_pc_q;

    assign push_entry.instr = imem_rdata;
    assign push_entry.pc    = inflight_pc_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = imem_rd_en;
        inflight_pc_d = inflight_pc_q;
        if (imem_rd_en) begin
            fetch_pc_d    = fetch_pc_q + 32'd4;
            inflight_pc_d = fetch_pc_q;
        end
        if (redirect) begin
            fetch_pc_d = redirect_target;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_queue (
        .clk_i       (clk),
        .reset_i     (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect),
        .valid_o     (out_valid),
        .head_o      (head_entry),
        .count_o     (count)
    );

    assign out_instr = head_entry.instr;
    assign out_pc    = head_entry.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a 1-cycle imem model that returns word = addr.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        imem_rd_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc_valid;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;
    bit done     = 0;

    fetch_queue #(
        .DEPTH      (4),
        .RESET_PC   (32'h0000_0000),
        .EXC_VECTOR (32'h0000_FFFC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_rd_en     (imem_rd_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_valid      (exc_valid),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .count          (count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= imem_rd_en ? imem_addr : 32'hDEAD_BEEF;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (!done) check_eq("count_le_depth", {31'b0, count <= 3'd4}, 32'd1);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc);
        check_eq({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check_eq({tag, "_pc"}, out_pc, pc);
        check_eq({tag, "_instr"}, out_instr, pc);
    endtask

    task automatic apply_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;
        #1;
    endtask

    initial begin
        reset = 1; out_ready = 1; redirect_valid = 0; redirect_pc = '0; exc_valid = 0;

        // Reset state and streaming start
        tick(); tick();
        check_eq("rst_count", {29'b0, count}, 32'd0);
        check_eq("rst_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_instr", out_instr, 32'd0);
        check_eq("rst_pc", out_pc, 32'd0);
        check_eq("rst_rd_en", {31'b0, imem_rd_en}, 32'd0);
        reset = 0; #1;
        check_eq("s_rd_en0", {31'b0, imem_rd_en}, 32'd1);
        check_eq("s_addr0", imem_addr, 32'h0);
        tick();
        check_eq("s_addr1", imem_addr, 32'h4);
        check_eq("s_valid1", {31'b0, out_valid}, 32'd0);
        tick();
        expect_head("s_head0", 32'h0);
        check_eq("s_addr2", imem_addr, 32'h8);
        tick(); expect_head("s_head4", 32'h4);
        tick(); expect_head("s_head8", 32'h8);

        // Exception wins over simultaneous branch, in-flight return discarded
        exc_valid = 1; redirect_valid = 1; redirect_pc = 32'h40; #1;
        tick();
        exc_valid = 0; redirect_valid = 0; #1;
        check_eq("e_valid1", {31'b0, out_valid}, 32'd0);
        check_eq("e_count1", {29'b0, count}, 32'd0);
        check_eq("e_addr1", imem_addr, 32'h0000_FFFC);
        tick();
        check_eq("e_valid2", {31'b0, out_valid}, 32'd0);
        check_eq("e_addr2", imem_addr, 32'h0001_0000);
        tick(); expect_head("e_head0", 32'h0000_FFFC);
        tick(); expect_head("e_head1", 32'h0001_0000);

        // Redirect near the top of the address space, PC wraps
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFF8; #1;
        tick();
        redirect_valid = 0; #1;
        check_eq("w_addr0", imem_addr, 32'hFFFF_FFF8);
        tick();
        check_eq("w_addr1", imem_addr, 32'hFFFF_FFFC);
        tick();
        check_eq("w_addr2", imem_addr, 32'h0000_0000);
        expect_head("w_head0", 32'hFFFF_FFF8);
        tick(); expect_head("w_head1", 32'hFFFF_FFFC);
        tick(); expect_head("w_head2", 32'h0000_0000);
        tick(); expect_head("w_head3", 32'h0000_0004);

        // Consumer stalled: fill to DEPTH, then drain back-to-back
        out_ready = 0;
        apply_reset();
        for (int i = 0; i < 9; i++) tick();
        check_eq("f_count", {29'b0, count}, 32'd4);
        check_eq("f_rd_en", {31'b0, imem_rd_en}, 32'd0);
        expect_head("f_head_stable", 32'h0);
        out_ready = 1; #1;
        check_eq("f_reissue_en", {31'b0, imem_rd_en}, 32'd1);
        check_eq("f_reissue_addr", imem_addr, 32'h10);
        tick(); expect_head("f_pop4", 32'h4);
        tick(); expect_head("f_pop8", 32'h8);
        tick(); expect_head("f_pop12", 32'hC);
        tick(); expect_head("f_pop16", 32'h10);

        // Branch redirect while full, misaligned target, then back-to-back redirects
        out_ready = 0;
        apply_reset();
        for (int i = 0; i < 5; i++) tick();
        check_eq("r_count_full", {29'b0, count}, 32'd4);
        redirect_valid = 1; redirect_pc = 32'h0000_0103; #1;
        tick();
        redirect_valid = 0; #1;
        check_eq("r_valid1", {31'b0, out_valid}, 32'd0);
        check_eq("r_count1", {29'b0, count}, 32'd0);
        check_eq("r_rd_en1", {31'b0, imem_rd_en}, 32'd1);
        check_eq("r_addr1", imem_addr, 32'h100);
        tick();
        check_eq("r_valid2", {31'b0, out_valid}, 32'd0);
        check_eq("r_addr2", imem_addr, 32'h104);
        tick(); expect_head("r_head", 32'h100);
        out_ready = 1; redirect_valid = 1; redirect_pc = 32'h200; #1;
        tick();
        redirect_pc = 32'h300; #1;
        tick();
        redirect_valid = 0; #1;
        check_eq("bb_addr", imem_addr, 32'h300);
        check_eq("bb_valid", {31'b0, out_valid}, 32'd0);
        tick();
        check_eq("bb_valid2", {31'b0, out_valid}, 32'd0);
        tick(); expect_head("bb_head", 32'h300);

        // Reset asserted with three entries queued
        out_ready = 0;
        apply_reset();
        for (int i = 0; i < 4; i++) tick();
        check_eq("mr_count3", {29'b0, count}, 32'd3);
        reset = 1; #1;
        check_eq("mr_rd_en_rst", {31'b0, imem_rd_en}, 32'd0);
        tick();
        check_eq("mr_count0", {29'b0, count}, 32'd0);
        check_eq("mr_valid0", {31'b0, out_valid}, 32'd0);
        reset = 0; out_ready = 1; #1;
        check_eq("mr_rd_en", {31'b0, imem_rd_en}, 32'd1);
        check_eq("mr_addr", imem_addr, 32'h0);
        tick();
        tick(); expect_head("mr_head0", 32'h0);
        tick(); expect_head("mr_head4", 32'h4);

        done = 1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
